decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; the ports SHALL be named clk and rst.
REQ-002 The ports SHALL be, with clock and reset first:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  instr is valid this cycle
- in_ready  out  1  stage accepts instr this cycle
- instr  in  32  fields: op[31:26], rs1[25:21], rs2[20:16], rd[15:11], imm[15:0]
- rf_src1_addr  out  5  register-file read port 1 address = instr[25:21] (combinational)
- rf_src2_addr  out  5  register-file read port 2 address = instr[20:16] (combinational)
- rf_read_data1  in  32  read port 1 data
- rf_read_data2  in  32  read port 2 data
- wb_valid  in  1  a writeback retires this cycle
- wb_dest_addr  in  5  writeback register
- wb_data  in  32  writeback data
- out_valid  out  1  decoded op held in the output register
- out_ready  in  1  downstream accepts
- out_op  out  6  opcode
- out_dest_addr  out  5  destination register
- out_wr_en  out  1  op writes a register
- out_opnd1  out  32  operand 1
- out_opnd2  out  32  operand 2
- out_imm  out  32  sign-extended imm

Function
REQ-003 Decode classes SHALL be:
- R (op=0x00): sources rs1 and rs2; dest rd; wr_en=1.
- I (op 0x01–0x1F): source rs1; dest=rs2 field; wr_en=1; out_opnd2=0.
- S (op 0x20–0x2F): sources rs1 and rs2; wr_en=0; out_dest_addr=0.
- All other ops: NOP; no sources; wr_en=0; out_dest_addr=0.
REQ-004 out_imm SHALL equal imm sign-extended to 32 bits for every class.
REQ-005 The scoreboard SHALL be a 32-bit pending vector.
- A bit is set at an accepted issue with wr_en=1 and dest≠0.
- A bit is cleared on wb_valid for wb_dest_addr.
- If set and clear hit the same address in the same cycle, set SHALL win.
- Bit 0 SHALL always read 0.
REQ-006 hazard SHALL be 1 when any used source register, or the destination when wr_en=1, is pending. Register 0 SHALL never cause a hazard.
REQ-007 in_ready SHALL equal (!out_valid || out_ready) && !hazard. It SHALL not depend on in_valid.
REQ-008 An instruction is accepted when in_valid && in_ready. out_valid SHALL rise the cycle after acceptance (latency 1).
REQ-009 Operands SHALL be captured from rf_read_data1/2 at acceptance. A source register of 0 SHALL yield operand 0.
REQ-010 While out_valid && !out_ready, all out_* SHALL hold their values.
REQ-011 out_valid SHALL clear when out_ready=1 and no new instruction is accepted. Back-to-back accepts SHALL sustain 1 op/cycle.
REQ-012 A wb_valid with wb_dest_addr=0 SHALL be ignored.

Reset
REQ-013 On rst at a clock edge:
- out_valid=0.
- out_op, out_dest_addr, out_wr_en, out_opnd1, out_opnd2 and out_imm SHALL be 0.
- The scoreboard SHALL be all zeros.
REQ-014 Reset mid-operation SHALL discard any held output op and all pending bits. in_ready SHALL be 0 during rst.

Configuration
REQ-015 Macro DECODE_BYPASS_EN:
- Defined: a source that is pending but matches wb_dest_addr with wb_valid=1 in the same cycle SHALL NOT cause a hazard, and its operand SHALL be wb_data.
- Undefined: any pending source stalls. Issue resumes the cycle after the scoreboard bit clears, and the operand is then read from the register file.

Structure
REQ-016 Package cpu_pkg SHALL hold:
- the opcode class ranges;
- the instruction field bit positions;
- a decoded-op struct typedef (op, dest, wr_en, opnd1, opnd2, imm).
REQ-017 The scoreboard SHALL be a sub-module named scoreboard, with set/clear ports and a pending vector output.

Verification
REQ-018 Reset, then R-op with op=0x00, rs1=3, rs2=4, rd=5, rf data 10 and 20 -> next cycle:
- out_valid=1, out_opnd1=10, out_opnd2=20, out_dest_addr=5, out_wr_en=1;
- pending[5]=1.
REQ-019 Immediately after REQ-018, I-op rs1=5 -> in_ready=0 until wb_valid, dest 5.
- Without the macro: accept 1 cycle after the writeback.
- With the macro: accept in the writeback cycle, with opnd1=wb_data.
REQ-020 I-op with imm=0xFFF0 -> out_imm=0xFFFFFFF0 and out_opnd2=0.
REQ-021 out_ready=0 for 3 cycles with out_valid=1 -> outputs stable and in_ready=0; out_ready=1 -> the next op issues without a bubble.
REQ-022 Issue to rd=7 and wb_valid dest 7 in the same cycle -> pending[7]=1 afterward.
REQ-023 rst asserted with out_valid=1 and pending[5]=1 -> next cycle out_valid=0, scoreboard 0, and a source 5 issues with no stall.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Instruction field positions, opcode class ranges and the
//                decoded-op record shared by the decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int c_op_msb  = 31;
    localparam int c_op_lsb  = 26;
    localparam int c_rs1_msb = 25;
    localparam int c_rs1_lsb = 21;
    localparam int c_rs2_msb = 20;
    localparam int c_rs2_lsb = 16;
    localparam int c_rd_msb  = 15;
    localparam int c_rd_lsb  = 11;
    localparam int c_imm_msb = 15;
    localparam int c_imm_lsb = 0;

    localparam logic [5:0] c_op_r    = 6'h00;
    localparam logic [5:0] c_op_i_lo = 6'h01;
    localparam logic [5:0] c_op_i_hi = 6'h1F;
    localparam logic [5:0] c_op_s_lo = 6'h20;
    localparam logic [5:0] c_op_s_hi = 6'h2F;

    typedef enum logic [1:0] {
        CLS_R   = 2'd0,
        CLS_I   = 2'd1,
        CLS_S   = 2'd2,
        CLS_NOP = 2'd3
    } op_class_e;

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  dest;
        logic        wr_en;
        logic [31:0] opnd1;
        logic [31:0] opnd2;
        logic [31:0] imm;
    } decoded_op_t;

    function automatic op_class_e op_class(input logic [5:0] op);
        if (op == c_op_r)
            return CLS_R;
        else if (op >= c_op_i_lo && op <= c_op_i_hi)
            return CLS_I;
        else if (op >= c_op_s_lo && op <= c_op_s_hi)
            return CLS_S;
        else
            return CLS_NOP;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : scoreboard
//  Description : 32-entry pending-write vector; a set beats a clear to the
//                same register, and register 0 is never pending.
//  Revision    : 1.0 - initial release
// ============================================================================
module scoreboard (
    input  logic        clk,
    input  logic        rst,
    input  logic        set_en,
    input  logic [4:0]  set_addr,
    input  logic        clr_en,
    input  logic [4:0]  clr_addr,
    output logic [31:0] pending
);

    localparam logic [31:0] c_keep_mask = 32'hFFFF_FFFE;

    logic [31:0] r_pending;
    logic [31:0] w_set_mask;
    logic [31:0] w_clr_mask;

    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (set_en)
            w_set_mask[set_addr] = 1'b1;
        if (clr_en)
            w_clr_mask[clr_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_pending <= '0;
        else
            r_pending <= ((r_pending & ~w_clr_mask) | w_set_mask) & c_keep_mask;
    end

    assign pending = r_pending;

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : Single-entry decode stage with scoreboard hazard stall.
//                Define DECODE_BYPASS_EN to forward same-cycle writebacks.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    output logic [4:0]  rf_src1_addr,
    output logic [4:0]  rf_src2_addr,
    input  logic [31:0] rf_read_data1,
    input  logic [31:0] rf_read_data2,
    input  logic        wb_valid,
    input  logic [4:0]  wb_dest_addr,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  out_op,
    output logic [4:0]  out_dest_addr,
    output logic        out_wr_en,
    output logic [31:0] out_opnd1,
    output logic [31:0] out_opnd2,
    output logic [31:0] out_imm
);

    logic [5:0]  w_op;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic [15:0] w_imm16;
    op_class_e   w_class;

    logic        w_use1;
    logic        w_use2;
    logic        w_wr_en;
    logic [4:0]  w_dest;
    logic [31:0] w_pending;
    logic        w_fwd1;
    logic        w_fwd2;
    logic        w_hazard;
    logic        w_accept;
    logic [31:0] w_src1_data;
    logic [31:0] w_src2_data;
    decoded_op_t w_dec;

    decoded_op_t r_out;
    logic        r_out_valid;

    assign w_op    = instr[c_op_msb:c_op_lsb];
    assign w_rs1   = instr[c_rs1_msb:c_rs1_lsb];
    assign w_rs2   = instr[c_rs2_msb:c_rs2_lsb];
    assign w_rd    = instr[c_rd_msb:c_rd_lsb];
    assign w_imm16 = instr[c_imm_msb:c_imm_lsb];
    assign w_class = op_class(w_op);

    assign rf_src1_addr = w_rs1;
    assign rf_src2_addr = w_rs2;

    always_comb begin
        w_use1  = 1'b0;
        w_use2  = 1'b0;
        w_wr_en = 1'b0;
        w_dest  = '0;
        unique case (w_class)
            CLS_R: begin
                w_use1  = 1'b1;
                w_use2  = 1'b1;
                w_wr_en = 1'b1;
                w_dest  = w_rd;
            end
            CLS_I: begin
                w_use1  = 1'b1;
                w_wr_en = 1'b1;
                w_dest  = w_rs2;
            end
            CLS_S: begin
                w_use1  = 1'b1;
                w_use2  = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef DECODE_BYPASS_EN
    // A pending source retiring this very cycle is taken straight off the writeback bus.
    assign w_fwd1 = wb_valid && (wb_dest_addr == w_rs1) && w_pending[w_rs1];
    assign w_fwd2 = wb_valid && (wb_dest_addr == w_rs2) && w_pending[w_rs2];
`else
    assign w_fwd1 = 1'b0;
    assign w_fwd2 = 1'b0;
`endif

    // Register 0 never reads pending, so it can never raise a hazard.
    assign w_hazard = (w_use1 && w_pending[w_rs1] && !w_fwd1)
                   || (w_use2 && w_pending[w_rs2] && !w_fwd2)
                   || (w_wr_en && w_pending[w_dest]);

    assign in_ready = !rst && (!r_out_valid || out_ready) && !w_hazard;
    assign w_accept = in_valid && in_ready;

    assign w_src1_data = (!w_use1 || w_rs1 == 5'd0) ? 32'd0 :
                         w_fwd1 ? wb_data : rf_read_data1;
    assign w_src2_data = (!w_use2 || w_rs2 == 5'd0) ? 32'd0 :
                         w_fwd2 ? wb_data : rf_read_data2;

    always_comb begin
        w_dec       = '0;
        w_dec.op    = w_op;
        w_dec.dest  = w_dest;
        w_dec.wr_en = w_wr_en;
        w_dec.opnd1 = w_src1_data;
        w_dec.opnd2 = w_src2_data;
        w_dec.imm   = {{16{w_imm16[15]}}, w_imm16};
    end

    scoreboard u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (w_accept && w_wr_en && (w_dest != 5'd0)),
        .set_addr (w_dest),
        .clr_en   (wb_valid && (wb_dest_addr != 5'd0)),
        .clr_addr (wb_dest_addr),
        .pending  (w_pending)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out       <= w_dec;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid     = r_out_valid;
    assign out_op        = r_out.op;
    assign out_dest_addr = r_out.dest;
    assign out_wr_en     = r_out.wr_en;
    assign out_opnd1     = r_out.opnd1;
    assign out_opnd2     = r_out.opnd2;
    assign out_imm       = r_out.imm;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_stage
//  Description : Random and directed bench for decode_stage with a reference
//                model and an expected-op queue drained by a monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [4:0]  rf_src1_addr;
    logic [4:0]  rf_src2_addr;
    logic [31:0] rf_read_data1;
    logic [31:0] rf_read_data2;
    logic        wb_valid;
    logic [4:0]  wb_dest_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_op;
    logic [4:0]  out_dest_addr;
    logic        out_wr_en;
    logic [31:0] out_opnd1;
    logic [31:0] out_opnd2;
    logic [31:0] out_imm;

    always #5 clk = ~clk;

    decode_stage u_dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .instr         (instr),
        .rf_src1_addr  (rf_src1_addr),
        .rf_src2_addr  (rf_src2_addr),
        .rf_read_data1 (rf_read_data1),
        .rf_read_data2 (rf_read_data2),
        .wb_valid      (wb_valid),
        .wb_dest_addr  (wb_dest_addr),
        .wb_data       (wb_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_op        (out_op),
        .out_dest_addr (out_dest_addr),
        .out_wr_en     (out_wr_en),
        .out_opnd1     (out_opnd1),
        .out_opnd2     (out_opnd2),
        .out_imm       (out_imm)
    );

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  dest;
        logic        wr_en;
        logic [31:0] opnd1;
        logic [31:0] opnd2;
        logic [31:0] imm;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rf_mem[32];
    logic [31:0] m_pend;
    logic        m_ov;
    logic [31:0] n_pend;
    logic        n_ov;
    logic        n_clear_q;
    int          n_pass = 0;
    int          n_total = 0;

    assign rf_read_data1 = rf_mem[instr[25:21]];
    assign rf_read_data2 = rf_mem[instr[20:16]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [15:0] imm);
        return {op, rs1, rs2, imm};
    endfunction

    // One clock cycle: drive, evaluate the model at negedge, commit after the edge.
    task automatic step(input logic r, input logic iv, input logic [31:0] ins,
                        input logic wv, input logic [4:0] wd, input logic [31:0] wdat,
                        input logic orr);
        logic [5:0] op;
        logic [4:0] rs1, rs2, rd, dst;
        logic       u1, u2, we, byp1, byp2, haz, exp_ready, acc;
        exp_t       e;
        rst = r; in_valid = iv; instr = ins; wb_valid = wv;
        wb_dest_addr = wd; wb_data = wdat; out_ready = orr;
        @(negedge clk);
        op = ins[31:26]; rs1 = ins[25:21]; rs2 = ins[20:16]; rd = ins[15:11];
        u1 = 1'b0; u2 = 1'b0; we = 1'b0; dst = 5'd0;
        if (op == 6'h00) begin
            u1 = 1'b1; u2 = 1'b1; we = 1'b1; dst = rd;
        end else if (op <= 6'h1F) begin
            u1 = 1'b1; we = 1'b1; dst = rs2;
        end else if (op <= 6'h2F) begin
            u1 = 1'b1; u2 = 1'b1;
        end
`ifdef DECODE_BYPASS_EN
        byp1 = wv && (wd == rs1) && m_pend[rs1];
        byp2 = wv && (wd == rs2) && m_pend[rs2];
`else
        byp1 = 1'b0;
        byp2 = 1'b0;
`endif
        haz = (u1 && m_pend[rs1] && !byp1) || (u2 && m_pend[rs2] && !byp2) || (we && m_pend[dst]);
        exp_ready = !r && (!m_ov || orr) && !haz;
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
        chk("pending", u_dut.w_pending, m_pend);
        acc = iv && exp_ready;
        if (acc) begin
            e.op    = op;
            e.dest  = dst;
            e.wr_en = we;
            e.opnd1 = (!u1 || rs1 == 5'd0) ? 32'd0 : (byp1 ? wdat : rf_mem[rs1]);
            e.opnd2 = (!u2 || rs2 == 5'd0) ? 32'd0 : (byp2 ? wdat : rf_mem[rs2]);
            e.imm   = 32'(signed'(ins[15:0]));
            exp_q.push_back(e);
        end
        n_clear_q = r;
        if (r) begin
            n_pend = '0;
            n_ov   = 1'b0;
        end else begin
            n_pend = m_pend;
            if (wv && wd != 5'd0) n_pend[wd] = 1'b0;
            if (acc && we && dst != 5'd0) n_pend[dst] = 1'b1;
            n_ov = acc ? 1'b1 : (orr ? 1'b0 : m_ov);
        end
        @(posedge clk);
        #1;
        m_pend = n_pend;
        m_ov   = n_ov;
        if (n_clear_q) exp_q.delete();
        if (wv && wd != 5'd0) rf_mem[wd] = wdat;
    endtask

    // Monitor: the held output always corresponds to the oldest queued op.
    always @(negedge clk) begin
        if (rst !== 1'b1 && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 32'd1, 32'd0);
            end else begin
                chk("out_op",    {26'd0, out_op},        {26'd0, exp_q[0].op});
                chk("out_dest",  {27'd0, out_dest_addr}, {27'd0, exp_q[0].dest});
                chk("out_wr_en", {31'd0, out_wr_en},     {31'd0, exp_q[0].wr_en});
                chk("out_opnd1", out_opnd1, exp_q[0].opnd1);
                chk("out_opnd2", out_opnd2, exp_q[0].opnd2);
                chk("out_imm",   out_imm,   exp_q[0].imm);
                if (out_ready === 1'b1) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] i1, ra, rb, rins;
        logic [4:0]  rs1r, rs2r, rdr;
        logic [5:0]  opr;
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'h1000 + 32'(i);
        rf_mem[0] = 32'hDEAD_BEEF;
        rf_mem[3] = 32'd10;
        rf_mem[4] = 32'd20;
        m_pend = '0; m_ov = 1'b0;
        rst = 1'b1; in_valid = 1'b0; instr = '0; wb_valid = 1'b0;
        wb_dest_addr = '0; wb_data = '0; out_ready = 1'b1;
        @(posedge clk); #1;

        step(1, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_op", {26'd0, out_op}, 32'd0);
        chk("rst_out_dest", {27'd0, out_dest_addr}, 32'd0);
        chk("rst_out_wr_en", {31'd0, out_wr_en}, 32'd0);
        chk("rst_out_opnd1", out_opnd1, 32'd0);
        chk("rst_out_opnd2", out_opnd2, 32'd0);
        chk("rst_out_imm", out_imm, 32'd0);

        // R-op rs1=3 rs2=4 rd=5
        step(0, 1, mk(6'h00, 5'd3, 5'd4, 16'h2800), 0, 0, 0, 1);
        chk("r_valid", {31'd0, out_valid}, 32'd1);
        chk("r_opnd1", out_opnd1, 32'd10);
        chk("r_opnd2", out_opnd2, 32'd20);
        chk("r_dest", {27'd0, out_dest_addr}, 32'd5);
        chk("r_wr_en", {31'd0, out_wr_en}, 32'd1);
        chk("r_pend5", {31'd0, u_dut.w_pending[5]}, 32'd1);

        // I-op reading pending r5
        i1 = mk(6'h01, 5'd5, 5'd6, 16'h0000);
        step(0, 1, i1, 0, 0, 0, 1);
        chk("raw_stall", {31'd0, in_ready}, 32'd0);
        step(0, 1, i1, 1, 5'd5, 32'h55, 1);
`ifdef DECODE_BYPASS_EN
        chk("byp_valid", {31'd0, out_valid}, 32'd1);
        chk("byp_opnd1", out_opnd1, 32'h55);
`else
        chk("nobyp_wait", {31'd0, out_valid}, 32'd0);
        step(0, 1, i1, 0, 0, 0, 1);
        chk("nobyp_valid", {31'd0, out_valid}, 32'd1);
        chk("nobyp_opnd1", out_opnd1, 32'h55);
`endif

        // Negative immediate, source 0
        step(0, 1, mk(6'h05, 5'd0, 5'd2, 16'hFFF0), 0, 0, 0, 1);
        chk("imm_sext", out_imm, 32'hFFFF_FFF0);
        chk("imm_opnd2", out_opnd2, 32'd0);
        chk("r0_opnd1", out_opnd1, 32'd0);

        // Downstream backpressure, then back-to-back issue
        ra = mk(6'h00, 5'd8, 5'd9, 16'h5000);
        rb = mk(6'h00, 5'd11, 5'd12, 16'h6800);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, ra, 0, 0, 0, 0);
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_op", {26'd0, out_op}, 32'h05);
        end
        step(0, 1, ra, 0, 0, 0, 1);
        chk("b2b_a", {27'd0, out_dest_addr}, 32'd10);
        step(0, 1, rb, 0, 0, 0, 1);
        chk("b2b_b", {27'd0, out_dest_addr}, 32'd13);
        chk("b2b_valid", {31'd0, out_valid}, 32'd1);
        step(0, 0, 0, 0, 0, 0, 1);

        // Set and clear of r7 in the same cycle
        step(0, 1, mk(6'h00, 5'd0, 5'd0, 16'h3800), 1, 5'd7, 32'h77, 1);
        chk("set_wins", {31'd0, u_dut.w_pending[7]}, 32'd1);
        step(0, 0, 0, 0, 0, 0, 1);

        // Reset while an op is held and r5 pending
        step(0, 1, mk(6'h00, 5'd0, 5'd0, 16'h2800), 0, 0, 0, 0);
        chk("pre_rst_pend5", {31'd0, u_dut.w_pending[5]}, 32'd1);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_pend", u_dut.w_pending, 32'd0);
        step(0, 1, mk(6'h01, 5'd5, 5'd1, 16'h0001), 0, 0, 0, 1);
        chk("post_rst_issue", {31'd0, out_valid}, 32'd1);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            case ($urandom_range(3))
                0: opr = 6'h00;
                1: opr = 6'($urandom_range(6'h1F, 6'h01));
                2: opr = 6'($urandom_range(6'h2F, 6'h20));
                default: opr = 6'($urandom_range(6'h3F, 6'h30));
            endcase
            rs1r = 5'($urandom_range(7));
            rs2r = 5'($urandom_range(7));
            rdr  = 5'($urandom_range(7));
            rins = mk(opr, rs1r, rs2r, {rdr, 11'($urandom())});
            step(($urandom_range(199) == 0), ($urandom_range(3) != 0), rins,
                 ($urandom_range(1) == 1), 5'($urandom_range(7)), $urandom(),
                 ($urandom_range(3) != 0));
        end

        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 0, 1);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
